// File: rtl/cv32e40s_pma_access_ctrl_if.sv
// Request/response/PMA signal bundle between the core-side requester, the
// PMA access controller, the OBI bus interface and the PMA checker.
interface cv32e40s_pma_access_ctrl_if;
    logic        core_trans_valid_i;
    logic        core_trans_ready_o;
    logic [31:0] core_trans_addr_i;
    logic        core_trans_we_i;
    logic        core_misaligned_i;

    logic        bus_trans_valid_o;
    logic        bus_trans_ready_i;
    logic [31:0] bus_trans_addr_o;
    logic        bus_trans_bufferable_o;
    logic        bus_trans_cacheable_o;

    logic        bus_resp_valid_i;
    logic [31:0] bus_resp_rdata_i;
    logic        bus_resp_err_i;

    logic        core_resp_valid_o;
    logic [31:0] core_resp_rdata_o;
    logic        core_resp_bus_err_o;
    logic        core_resp_pma_err_o;

    logic [31:0] pma_addr_o;
    logic        pma_instr_fetch_o;
    logic        pma_misaligned_o;
    logic        pma_load_o;
    logic        pma_err_i;
    logic        pma_bufferable_i;
    logic        pma_cacheable_i;

    // Controller view
    modport master (
        input  core_trans_valid_i, core_trans_addr_i, core_trans_we_i, core_misaligned_i,
        output core_trans_ready_o,
        output bus_trans_valid_o, bus_trans_addr_o, bus_trans_bufferable_o, bus_trans_cacheable_o,
        input  bus_trans_ready_i,
        input  bus_resp_valid_i, bus_resp_rdata_i, bus_resp_err_i,
        output core_resp_valid_o, core_resp_rdata_o, core_resp_bus_err_o, core_resp_pma_err_o,
        output pma_addr_o, pma_instr_fetch_o, pma_misaligned_o, pma_load_o,
        input  pma_err_i, pma_bufferable_i, pma_cacheable_i
    );

    // Environment view (core, bus and PMA checker)
    modport slave (
        output core_trans_valid_i, core_trans_addr_i, core_trans_we_i, core_misaligned_i,
        input  core_trans_ready_o,
        input  bus_trans_valid_o, bus_trans_addr_o, bus_trans_bufferable_o, bus_trans_cacheable_o,
        output bus_trans_ready_i,
        output bus_resp_valid_i, bus_resp_rdata_i, bus_resp_err_i,
        input  core_resp_valid_o, core_resp_rdata_o, core_resp_bus_err_o, core_resp_pma_err_o,
        input  pma_addr_o, pma_instr_fetch_o, pma_misaligned_o, pma_load_o,
        output pma_err_i, pma_bufferable_i, pma_cacheable_i
    );
endinterface

// File: rtl/cv32e40s_pma_access_ctrl.sv
// Gates core requests through the PMA checker; illegal requests are answered
// locally with a PMA error, ordered behind all outstanding bus responses.
module cv32e40s_pma_access_ctrl #(
    parameter int IF_STAGE        = 0,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic                               clk,
    input logic                               rst_n,
    cv32e40s_pma_access_ctrl_if.master        acc
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_OUTST = 2'd1,
        RESP_ERR   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt;
    logic          bus_hs;
    logic          cnt_room;
    logic          last_resp;

    assign bus_hs    = acc.bus_trans_valid_o && acc.bus_trans_ready_i;
    assign cnt_room  = cnt < MAX_CNT;
    assign last_resp = (cnt == ONE_CNT) && acc.bus_resp_valid_i;

    // Address and attributes are pure pass-through, no added latency
    assign acc.bus_trans_addr_o       = acc.core_trans_addr_i;
    assign acc.pma_addr_o             = acc.core_trans_addr_i;
    assign acc.pma_misaligned_o       = acc.core_misaligned_i;
    assign acc.bus_trans_bufferable_o = acc.pma_bufferable_i;
    assign acc.bus_trans_cacheable_o  = acc.pma_cacheable_i;
    assign acc.pma_instr_fetch_o      = (IF_STAGE != 0);
    assign acc.pma_load_o             = (IF_STAGE != 0) ? 1'b0
                                        : (acc.core_trans_valid_i && !acc.core_trans_we_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (bus_hs && !acc.bus_resp_valid_i) begin
            cnt <= cnt + ONE_CNT;
        end else if (!bus_hs && acc.bus_resp_valid_i) begin
            cnt <= cnt - ONE_CNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc.core_trans_valid_i && acc.pma_err_i)
                    state_d = ((cnt == '0) || last_resp) ? RESP_ERR : WAIT_OUTST;
            end
            WAIT_OUTST: begin
                if (last_resp) state_d = RESP_ERR;
            end
            RESP_ERR: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        acc.core_trans_ready_o  = 1'b0;
        acc.bus_trans_valid_o   = 1'b0;
        acc.core_resp_valid_o   = acc.bus_resp_valid_i;
        acc.core_resp_rdata_o   = acc.bus_resp_rdata_i;
        acc.core_resp_bus_err_o = acc.bus_resp_err_i;
        acc.core_resp_pma_err_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc.pma_err_i) begin
                    // Illegal request is swallowed here and never reaches the bus
                    acc.core_trans_ready_o = acc.core_trans_valid_i;
                end else begin
                    acc.bus_trans_valid_o  = acc.core_trans_valid_i && cnt_room;
                    acc.core_trans_ready_o = acc.bus_trans_ready_i && cnt_room;
                end
            end
            RESP_ERR: begin
                acc.core_resp_valid_o   = 1'b1;
                acc.core_resp_rdata_o   = '0;
                acc.core_resp_bus_err_o = 1'b0;
                acc.core_resp_pma_err_o = 1'b1;
            end
            default: ;
        endcase
    end

    a_cnt_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus_hs && !acc.bus_resp_valid_i && (cnt == MAX_CNT)));
    a_cnt_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(acc.bus_resp_valid_i && !bus_hs && (cnt == '0)));
    a_no_resp_in_err: assert property (@(posedge clk) disable iff (!rst_n)
        !((state_q == RESP_ERR) && acc.bus_resp_valid_i));

endmodule

// File: tb/tb_cv32e40s_pma_access_ctrl.sv
// Randomised core/bus/PMA traffic against an in-order response reference model,
// plus a directed instruction-fetch instance.
module tb_cv32e40s_pma_access_ctrl;
    localparam int MAX = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cv32e40s_pma_access_ctrl_if a();
    cv32e40s_pma_access_ctrl_if b();

    cv32e40s_pma_access_ctrl #(.IF_STAGE(0), .MAX_OUTSTANDING(MAX)) u_lsu (
        .clk(clk), .rst_n(rst_n), .acc(a.master));
    cv32e40s_pma_access_ctrl #(.IF_STAGE(1), .MAX_OUTSTANDING(MAX)) u_if (
        .clk(clk), .rst_n(rst_n), .acc(b.master));

    typedef struct {
        bit          is_err;
        logic [31:0] rdata;
        bit          berr;
        int          due;
    } item_t;

    item_t exp_q[$];  // responses the core must see, in order
    item_t bus_q[$];  // transactions accepted by the bus, awaiting response

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int reset_hits = 0;
    bit req_active = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // PMA checker stand-in: top quarter of memory is illegal
    function automatic bit pma_bad(input logic [31:0] ad);
        return ad[31:30] == 2'b11;
    endfunction

    task automatic drive_pma(input logic [31:0] ad);
        a.pma_err_i        = pma_bad(ad);
        a.pma_bufferable_i = ad[4];
        a.pma_cacheable_i  = ad[5];
    endtask

    task automatic idle_inputs();
        a.core_trans_valid_i = 0; a.core_trans_addr_i = '0; a.core_trans_we_i = 0;
        a.core_misaligned_i  = 0; a.bus_trans_ready_i = 0;  a.bus_resp_valid_i = 0;
        a.bus_resp_rdata_i   = '0; a.bus_resp_err_i = 0;
        drive_pma('0);
        b.core_trans_valid_i = 0; b.core_trans_addr_i = '0; b.core_trans_we_i = 0;
        b.core_misaligned_i  = 0; b.bus_trans_ready_i = 0;  b.bus_resp_valid_i = 0;
        b.bus_resp_rdata_i   = '0; b.bus_resp_err_i = 0;
        b.pma_err_i = 0; b.pma_bufferable_i = 0; b.pma_cacheable_i = 0;
    endtask

    task automatic drive_cycle(input int rdy_pct, input int rsp_pct);
        logic [31:0] ad;
        if (!req_active && $urandom_range(0, 99) < 60) begin
            ad = $urandom;
            a.core_trans_addr_i  = ad;
            a.core_trans_we_i    = $urandom_range(0, 1);
            a.core_misaligned_i  = $urandom_range(0, 1);
            a.core_trans_valid_i = 1;
            req_active = 1;
        end else if (!req_active) begin
            a.core_trans_valid_i = 0;
        end
        drive_pma(a.core_trans_addr_i);
        a.bus_trans_ready_i = ($urandom_range(0, 99) < rdy_pct);
        if (bus_q.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
            a.bus_resp_valid_i = 1;
            a.bus_resp_rdata_i = bus_q[0].rdata;
            a.bus_resp_err_i   = bus_q[0].berr;
        end else begin
            a.bus_resp_valid_i = 0;
            a.bus_resp_rdata_i = $urandom;
            a.bus_resp_err_i   = $urandom_range(0, 1);
        end
    endtask

    task automatic check_cycle();
        int    outst;
        bit    blk, v, perr, exp_bv, exp_rdy;
        item_t h, n;
        outst = bus_q.size();
        blk = 0;
        foreach (exp_q[i]) if (exp_q[i].is_err) blk = 1;
        v    = a.core_trans_valid_i;
        perr = pma_bad(a.core_trans_addr_i);
        exp_bv  = v && !perr && !blk && (outst < MAX);
        exp_rdy = blk ? 1'b0 : (perr ? v : (a.bus_trans_ready_i && (outst < MAX)));

        chk("bus_valid", a.bus_trans_valid_o, exp_bv);
        chk("core_ready", a.core_trans_ready_o, exp_rdy);
        chk("bus_addr", a.bus_trans_addr_o, a.core_trans_addr_i);
        chk("pma_addr", a.pma_addr_o, a.core_trans_addr_i);
        chk("attr", {a.bus_trans_bufferable_o, a.bus_trans_cacheable_o},
            {a.core_trans_addr_i[4], a.core_trans_addr_i[5]});
        chk("pma_flags", {a.pma_instr_fetch_o, a.pma_load_o, a.pma_misaligned_o},
            {1'b0, v && !a.core_trans_we_i, a.core_misaligned_i});

        if (a.bus_resp_valid_i) begin
            h = exp_q.pop_front();
            void'(bus_q.pop_front());
            chk("order_kind", h.is_err, 0);
            chk("resp_valid", a.core_resp_valid_o, 1);
            chk("resp_rdata", a.core_resp_rdata_o, h.rdata);
            chk("resp_flags", {a.core_resp_bus_err_o, a.core_resp_pma_err_o}, {h.berr, 1'b0});
        end else if (exp_q.size() > 0 && exp_q[0].is_err && exp_q[0].due == cyc) begin
            void'(exp_q.pop_front());
            chk("err_valid", a.core_resp_valid_o, 1);
            chk("err_rdata", a.core_resp_rdata_o, 0);
            chk("err_flags", {a.core_resp_bus_err_o, a.core_resp_pma_err_o}, 2'b01);
        end else begin
            chk("resp_idle", a.core_resp_valid_o, 0);
        end

        if (v && exp_rdy) begin
            n.is_err = perr;
            n.rdata  = $urandom;
            n.berr   = $urandom_range(0, 1);
            n.due    = 0;
            exp_q.push_back(n);
            if (!perr) bus_q.push_back(n);
            req_active = 0;
        end
        // An error answer is due one cycle after everything ahead of it is done
        if (exp_q.size() > 0 && exp_q[0].is_err && exp_q[0].due == 0)
            exp_q[0].due = cyc + 1;
    endtask

    initial begin
        int rdy_tab[4] = '{90, 50, 95, 30};
        int rsp_tab[4] = '{70, 30, 10, 50};
        int ph;
        idle_inputs();
        #3;
        chk("rst_resp_valid", a.core_resp_valid_o, 0);
        chk("rst_bus_valid", a.bus_trans_valid_o, 0);
        #9 rst_n = 1'b1;

        for (cyc = 1; cyc <= 1600; cyc++) begin
            @(posedge clk); #1;
            ph = (cyc / 200) % 4;
            if (bus_q.size() == 1 && exp_q.size() > 0 && exp_q[exp_q.size()-1].is_err
                && reset_hits < 3 && $urandom_range(0, 3) == 0) begin
                // Asynchronous reset while waiting behind one outstanding response
                idle_inputs();
                rst_n = 1'b0;
                #1;
                chk("midrst_resp_valid", a.core_resp_valid_o, 0);
                chk("midrst_ready", a.core_trans_ready_o, 0);
                exp_q.delete();
                bus_q.delete();
                req_active = 0;
                reset_hits++;
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end
            drive_cycle(rdy_tab[ph], rsp_tab[ph]);
            @(negedge clk);
            check_cycle();
        end
        chk("midrst_seen", (reset_hits > 0), 1);

        // Drain the LSU instance, then exercise the fetch instance
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        exp_q.delete(); bus_q.delete();

        @(posedge clk); #1;
        b.core_trans_valid_i = 1;
        b.core_trans_addr_i  = 32'hF000_0010;
        b.pma_err_i          = 1;
        b.bus_trans_ready_i  = 1;
        @(negedge clk);
        chk("if_flags", {b.pma_instr_fetch_o, b.pma_load_o}, 2'b10);
        chk("if_bus_valid", b.bus_trans_valid_o, 0);
        chk("if_ready", b.core_trans_ready_o, 1);
        chk("if_resp_early", b.core_resp_valid_o, 0);
        @(posedge clk); #1;
        b.core_trans_valid_i = 0;
        b.pma_err_i          = 0;
        @(negedge clk);
        chk("if_err_resp", {b.core_resp_valid_o, b.core_resp_pma_err_o, b.core_resp_bus_err_o}, 3'b110);
        chk("if_err_rdata", b.core_resp_rdata_o, 0);
        chk("if_err_bus_valid", b.bus_trans_valid_o, 0);
        @(posedge clk); #1;
        b.core_trans_valid_i = 1;
        b.core_trans_addr_i  = 32'h0000_1000;
        @(negedge clk);
        chk("if_err_once", b.core_resp_valid_o, 0);
        chk("if_legal_bus", {b.bus_trans_valid_o, b.core_trans_ready_o}, 2'b11);
        @(posedge clk); #1;
        b.core_trans_valid_i = 0;
        b.bus_resp_valid_i   = 1;
        b.bus_resp_rdata_i   = 32'h1234_5678;
        @(negedge clk);
        chk("if_legal_resp", {b.core_resp_valid_o, b.core_resp_pma_err_o}, 2'b10);
        chk("if_legal_rdata", b.core_resp_rdata_o, 32'h1234_5678);
        @(posedge clk); #1;
        b.bus_resp_valid_i = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
